// File: rtl/signed_div_sequencer_pkg.sv
// Shared ALU divider definitions: state encoding and sizing constants
// used by the signed/unsigned divide sequencer.
package signed_div_sequencer_pkg;

   localparam int DATA_W = 16;
   localparam int CNT_W  = $clog2(DATA_W);

   localparam logic [DATA_W-1:0] DIV_ZERO_QUOTIENT = {DATA_W{1'b1}};

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      DIV  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/signed_div_sequencer_sign.sv
// Sign/magnitude helpers shared with the ALU: absolute value and
// sign application (with overflow when the signed result cannot be represented).
module abs_value #(
   parameter int W = 16
) (
   input  logic [W-1:0] value,
   output logic [W-1:0] magnitude
);

   // Most-negative input maps to the unsigned magnitude 2^(W-1).
   always_comb begin
      if (value[W-1]) begin
         magnitude = {W{1'b0}} - value;
      end else begin
         magnitude = value;
      end
   end

endmodule

module give_sign #(
   parameter int W = 16
) (
   input  logic         sign,
   input  logic [W-1:0] magnitude,
   output logic [W-1:0] value,
   output logic         overflow
);

   // Negative results may reach -2^(W-1); positive ones must stay below 2^(W-1).
   always_comb begin
      if (sign) begin
         value    = {W{1'b0}} - magnitude;
         overflow = magnitude[W-1] & (|magnitude[W-2:0]);
      end else begin
         value    = magnitude;
         overflow = magnitude[W-1];
      end
   end

endmodule

// File: rtl/signed_div_sequencer_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract
// the divisor magnitude, keep or restore the partial remainder.
module restoring_div_step #(
   parameter int W = 16
) (
   input  logic [W:0]   rem_in,
   input  logic [W-1:0] quo_in,
   input  logic [W-1:0] divisor,
   output logic [W:0]   rem_out,
   output logic [W-1:0] quo_out
);

   logic [W+1:0] shifted;
   logic [W+1:0] diff;

   // The extra top bit of diff is the borrow that marks a negative trial result.
   always_comb begin
      shifted = {rem_in, quo_in[W-1]};
      diff    = shifted - {2'b00, divisor};
      if (diff[W+1]) begin
         rem_out = shifted[W:0];
         quo_out = {quo_in[W-2:0], 1'b0};
      end else begin
         rem_out = diff[W:0];
         quo_out = {quo_in[W-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/signed_div_sequencer.sv
// Multi-cycle signed/unsigned divider controller: magnitudes in PREP,
// one restoring bit per DIV cycle, sign restoration in FIX.
module signed_div_sequencer
   import signed_div_sequencer_pkg::*;
#(
   parameter int l = DATA_W
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         Start,
   input  logic         Signed,
   input  logic [l-1:0] Dividend,
   input  logic [l-1:0] Divisor,
   output logic         Busy,
   output logic         Done,
   output logic [l-1:0] Quotient,
   output logic [l-1:0] Remainder,
   output logic         DivByZero,
   output logic         Overflow
);

   localparam int CW = (l > 1) ? $clog2(l) : 1;

   state_t          state;
   logic            sgn;
   logic [l-1:0]    op_a;
   logic [l-1:0]    op_b;
   logic [l-1:0]    dmag;
   logic [l-1:0]    quo;
   logic [l:0]      rem;
   logic            sign_q;
   logic            sign_r;
   logic [CW-1:0]   count;

   logic [l-1:0]    abs_a;
   logic [l-1:0]    abs_b;
   logic [l-1:0]    mag_a;
   logic [l-1:0]    mag_b;
   logic [l:0]      step_rem;
   logic [l-1:0]    step_quo;
   logic [l-1:0]    fix_q;
   logic [l-1:0]    fix_r;
   logic            ovf_q;
   logic            ovf_r;

   abs_value #(.W(l)) u_abs_a (.value(op_a), .magnitude(abs_a));
   abs_value #(.W(l)) u_abs_b (.value(op_b), .magnitude(abs_b));

   // Unsigned operations bypass the absolute-value path.
   always_comb begin
      if (sgn) begin
         mag_a = abs_a;
         mag_b = abs_b;
      end else begin
         mag_a = op_a;
         mag_b = op_b;
      end
   end

   restoring_div_step #(.W(l)) u_step (
      .rem_in  (rem),
      .quo_in  (quo),
      .divisor (dmag),
      .rem_out (step_rem),
      .quo_out (step_quo)
   );

   give_sign #(.W(l)) u_sign_q (.sign(sign_q), .magnitude(quo),        .value(fix_q), .overflow(ovf_q));
   give_sign #(.W(l)) u_sign_r (.sign(sign_r), .magnitude(rem[l-1:0]), .value(fix_r), .overflow(ovf_r));

   // Sequencer FSM; all result outputs are loaded only on the edge entering DONE.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= IDLE;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         Quotient  <= {l{1'b0}};
         Remainder <= {l{1'b0}};
         DivByZero <= 1'b0;
         Overflow  <= 1'b0;
         sgn       <= 1'b0;
         op_a      <= {l{1'b0}};
         op_b      <= {l{1'b0}};
         dmag      <= {l{1'b0}};
         quo       <= {l{1'b0}};
         rem       <= {(l+1){1'b0}};
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         count     <= {CW{1'b0}};
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (Start) begin
                  op_a  <= Dividend;
                  op_b  <= Divisor;
                  sgn   <= Signed;
                  Busy  <= 1'b1;
                  state <= PREP;
               end else begin
                  Busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            PREP: begin
               sign_q <= sgn & (op_a[l-1] ^ op_b[l-1]);
               sign_r <= sgn & op_a[l-1];
               dmag   <= mag_b;
               quo    <= mag_a;
               rem    <= {(l+1){1'b0}};
               count  <= {CW{1'b0}};
               if (op_b == {l{1'b0}}) begin
                  Quotient  <= {l{1'b1}};
                  Remainder <= op_a;
                  DivByZero <= 1'b1;
                  Overflow  <= 1'b0;
                  Done      <= 1'b1;
                  Busy      <= 1'b0;
                  state     <= DONE;
               end else begin
                  state <= DIV;
               end
            end
            DIV: begin
               rem   <= step_rem;
               quo   <= step_quo;
               count <= count + CW'(1);
               if (count == CW'(l - 1)) begin
                  state <= FIX;
               end else begin
                  state <= DIV;
               end
            end
            FIX: begin
               // Remainder magnitude is always below the divisor, so ovf_r stays low in signed mode.
               Quotient  <= fix_q;
               Remainder <= fix_r;
               Overflow  <= sgn & (ovf_q | ovf_r);
               DivByZero <= 1'b0;
               Done      <= 1'b1;
               Busy      <= 1'b0;
               state     <= DONE;
            end
            default: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_signed_div_sequencer.sv
// Directed + random bench for signed_div_sequencer using an expected-result
// queue filled at issue time and drained when Done arrives.
module tb_signed_div_sequencer;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
      logic        ovf;
      int          lat;
   } exp_t;

   logic        Clock;
   logic        Reset;
   logic        Start;
   logic        Signed;
   logic [15:0] Dividend;
   logic [15:0] Divisor;
   logic        Busy;
   logic        Done;
   logic [15:0] Quotient;
   logic [15:0] Remainder;
   logic        DivByZero;
   logic        Overflow;

   int   checks;
   int   failures;
   exp_t sb_q[$];

   signed_div_sequencer #(.l(16)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Start     (Start),
      .Signed    (Signed),
      .Dividend  (Dividend),
      .Divisor   (Divisor),
      .Busy      (Busy),
      .Done      (Done),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .DivByZero (DivByZero),
      .Overflow  (Overflow)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] q, input logic [15:0] r, input logic dbz, input logic ovf, input int lat);
      exp_t e;
      e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.lat = lat;
      return e;
   endfunction

   // Reference: integer arithmetic with RISC-V style corner cases.
   function automatic exp_t model(input logic s, input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      int   sa;
      int   sd;
      e = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 19);
      if (b == 16'h0000) begin
         e = mk(16'hFFFF, a, 1'b1, 1'b0, 2);
      end else if (s) begin
         sa = int'($signed(a));
         sd = int'($signed(b));
         if (sa == -32768 && sd == -1) begin
            e = mk(16'h8000, 16'h0000, 1'b0, 1'b1, 19);
         end else begin
            e.q = 16'(sa / sd);
            e.r = 16'(sa % sd);
         end
      end else begin
         e.q = a / b;
         e.r = a % b;
      end
      return e;
   endfunction

   task automatic issue(input logic s, input logic [15:0] a, input logic [15:0] b, input exp_t e);
      Signed   = s;
      Dividend = a;
      Divisor  = b;
      Start    = 1'b1;
      sb_q.push_back(e);
      tick();
      Start = 1'b0;
   endtask

   task automatic collect(input string tag, input int elapsed);
      int   n;
      exp_t e;
      n = elapsed;
      while (Done !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      e = sb_q.pop_front();
      check({tag, "_lat"}, n, e.lat);
      check({tag, "_q"}, Quotient, e.q);
      check({tag, "_r"}, Remainder, e.r);
      check({tag, "_dbz"}, DivByZero, e.dbz);
      check({tag, "_ovf"}, Overflow, e.ovf);
      check({tag, "_busy"}, Busy, 1'b0);
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rs;
      int          seen;

      checks   = 0;
      failures = 0;
      Reset    = 1'b1;
      Start    = 1'b0;
      Signed   = 1'b0;
      Dividend = 16'h0000;
      Divisor  = 16'h0000;
      tick();
      tick();
      Reset = 1'b0;
      check("rst_busy", Busy, 1'b0);
      check("rst_done", Done, 1'b0);
      check("rst_q", Quotient, 16'h0000);
      check("rst_r", Remainder, 16'h0000);
      check("rst_dbz", DivByZero, 1'b0);
      check("rst_ovf", Overflow, 1'b0);
      tick();

      issue(1'b1, 16'd100, 16'd7, mk(16'd14, 16'd2, 1'b0, 1'b0, 19));
      check("busy_prep", Busy, 1'b1);
      collect("s100_7", 1);
      tick();
      check("done_pulse", Done, 1'b0);

      issue(1'b1, 16'hFFF9, 16'h0002, mk(16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 19));
      collect("sm7_2", 1);
      tick();

      issue(1'b1, 16'h8000, 16'hFFFF, mk(16'h8000, 16'h0000, 1'b0, 1'b1, 19));
      collect("s_ovf", 1);
      tick();
      issue(1'b0, 16'h8000, 16'hFFFF, mk(16'h0000, 16'h8000, 1'b0, 1'b0, 19));
      collect("u_8000", 1);
      tick();

      issue(1'b1, 16'h0005, 16'h0000, mk(16'hFFFF, 16'h0005, 1'b1, 1'b0, 2));
      collect("s_dz", 1);
      tick();
      issue(1'b0, 16'h0005, 16'h0000, mk(16'hFFFF, 16'h0005, 1'b1, 1'b0, 2));
      collect("u_dz", 1);
      tick();

      // Second Start while busy must be dropped; Start in the DONE cycle is taken.
      issue(1'b0, 16'hFFFF, 16'h0002, mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 19));
      tick(); tick(); tick(); tick();
      check("busy_c5", Busy, 1'b1);
      Signed   = 1'b1;
      Dividend = 16'h0010;
      Divisor  = 16'h0004;
      Start    = 1'b1;
      tick();
      Start = 1'b0;
      collect("ignore", 6);
      issue(1'b1, 16'd1000, 16'hFFF6, mk(16'hFF9C, 16'h0000, 1'b0, 1'b0, 19));
      check("b2b_busy", Busy, 1'b1);
      collect("b2b", 1);
      tick();

      // Mid-operation reset aborts without a Done.
      issue(1'b0, 16'h1234, 16'h0003, mk(16'h0611, 16'h0001, 1'b0, 1'b0, 19));
      tick(); tick(); tick(); tick(); tick(); tick(); tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      sb_q.delete();
      check("abort_busy", Busy, 1'b0);
      check("abort_done", Done, 1'b0);
      check("abort_q", Quotient, 16'h0000);
      check("abort_r", Remainder, 16'h0000);
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (Done === 1'b1) seen++;
      end
      check("abort_no_done", seen, 0);
      issue(1'b0, 16'd9, 16'd3, mk(16'd3, 16'd0, 1'b0, 1'b0, 19));
      collect("after_rst", 1);
      tick();

      for (int i = 0; i < 8; i++) begin
         ra = 16'($urandom);
         rb = (i == 5) ? 16'h0000 : ((i % 2 == 0) ? 16'($urandom_range(1, 40)) : 16'($urandom));
         if (i == 6) rb = 16'hFFFF;
         rs = 1'(i % 3 != 0);
         issue(rs, ra, rb, model(rs, ra, rb));
         collect($sformatf("rnd%0d", i), 1);
      end
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
